// File: rtl/regfile_dump.sv
// Register file debug reader: walks which_reg, waits for the read to settle,
// and streams (index, data) words out over a valid/ready port.
module regfile_dump #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int SETTLE   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              single,
    input  logic [ADDR_W-1:0] sel,
    output logic [ADDR_W-1:0] which_reg,
    input  logic [DATA_W-1:0] reg_content,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0]        CNT_INIT = 4'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx;
    logic              mode_single;
    logic              last;

    // which_reg is the sweep index itself, so it keeps the last index after DONE
    assign which_reg = idx;
    assign last      = mode_single || (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt == 4'd0) state_nx = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) state_nx = last ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (1'b1)
            (state == S_PRESENT): begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            (state == S_DONE): begin
                done = 1'b1;
                busy = 1'b1;
            end
            (state == S_SETTLE): busy = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            cnt         <= '0;
            mode_single <= 1'b0;
            out_idx     <= '0;
            out_data    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        idx         <= single ? sel : '0;
                        mode_single <= single;
                        cnt         <= CNT_INIT;
                    end
                end
                S_SETTLE: begin
                    if (cnt == 4'd0) begin
                        out_data <= reg_content;
                        out_idx  <= idx;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_PRESENT: begin
                    if (out_ready && !last) begin
                        idx <= idx + 1'b1;
                        cnt <= CNT_INIT;
                    end
                end
                S_DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: single-register table, full sweeps,
// backpressure, ignored starts, live data and asynchronous reset.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        single;
    logic [4:0]  sel;
    logic [4:0]  which_reg;
    logic [31:0] reg_content;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_idx;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] regs [0:15];

    int applied = 0;
    int miscompares = 0;

    logic [36:0] words [$];
    int          at [$];
    int          n_done;
    int          done_at;
    int          idle_at;
    bit          ok;

    typedef struct {
        logic [4:0]  sel;
        logic [3:0]  wr;
        logic [31:0] val;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [5];

    regfile_dump dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .single(single),
        .sel(sel),
        .which_reg(which_reg),
        .reg_content(reg_content),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx(out_idx),
        .out_data(out_data),
        .busy(busy),
        .done(done)
    );

    // unmapped indices read back as r0
    assign reg_content = (which_reg < 5'd16) ? regs[which_reg[3:0]] : regs[0];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic s, input logic [4:0] sl);
        @(negedge clk);
        start  = 1'b1;
        single = s;
        sel    = sl;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic drain(input bit rnd, input bit poke, input int poke_at,
                         input bit live, input int max_cyc);
        bit          held;
        logic [4:0]  h_idx;
        logic [31:0] h_data;
        words.delete();
        at.delete();
        n_done  = 0;
        done_at = 0;
        idle_at = 0;
        held    = 0;
        h_idx   = '0;
        h_data  = '0;
        ok      = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (held) begin
                chk("hold_idx", 64'(out_idx), 64'(h_idx));
                chk("hold_data", 64'(out_data), 64'(h_data));
            end
            start     = poke && (c == poke_at || done);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                n_done++;
                done_at = c;
            end
            if (live && out_valid && out_idx == 5'd3) regs[3] = 32'd9;
            if (out_valid && out_ready) begin
                words.push_back({out_idx, out_data});
                at.push_back(c);
            end
            held   = out_valid && !out_ready;
            h_idx  = out_idx;
            h_data = out_data;
            if (n_done > 0 && !busy) begin
                idle_at = c;
                ok = 1;
                break;
            end
        end
        start = 1'b0;
        chk("drain_in_budget", 64'(ok), 64'd1);
    endtask

    task automatic check_sweep(input bit data_std, input bit rate);
        chk("sweep_count", 64'(words.size()), 64'd16);
        for (int k = 0; k < words.size(); k++) begin
            chk("sweep_idx", 64'(words[k][36:32]), 64'(k));
            if (data_std)
                chk("sweep_data", 64'(words[k][31:0]), 64'(32'hA000_0000 + k));
            if (rate) chk("sweep_cycle", 64'(at[k]), 64'(2 + 3 * k));
        end
        chk("sweep_done_pulses", 64'(n_done), 64'd1);
        chk("sweep_busy_drop", 64'(idle_at), 64'(done_at + 1));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        single    = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) regs[k] = '0;

        tbl[0] = '{sel: 5'd7,  wr: 4'd7,  val: 32'hDEAD_BEEF, exp: 32'hDEAD_BEEF};
        tbl[1] = '{sel: 5'd0,  wr: 4'd0,  val: 32'h1234_5678, exp: 32'h1234_5678};
        tbl[2] = '{sel: 5'd15, wr: 4'd15, val: 32'hCAFE_F00D, exp: 32'hCAFE_F00D};
        tbl[3] = '{sel: 5'd20, wr: 4'd0,  val: 32'h0000_0BAD, exp: 32'h0000_0BAD};
        tbl[4] = '{sel: 5'd31, wr: 4'd5,  val: 32'h5555_5555, exp: 32'h0000_0BAD};

        #1;
        chk("rst_which_reg", 64'(which_reg), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            regs[tbl[i].wr] = tbl[i].val;
            out_ready = 1'b1;
            do_start(1'b1, tbl[i].sel);
            drain(0, 0, 0, 0, 50);
            chk("single_count", 64'(words.size()), 64'd1);
            if (words.size() > 0) begin
                chk("single_idx", 64'(words[0][36:32]), 64'(tbl[i].sel));
                chk("single_data", 64'(words[0][31:0]), 64'(tbl[i].exp));
                chk("single_latency", 64'(at[0]), 64'd2);
            end
            chk("single_done", 64'(n_done), 64'd1);
            chk("single_which_reg", 64'(which_reg), 64'(tbl[i].sel));
        end

        for (int k = 0; k < 16; k++) regs[k] = 32'hA000_0000 + k;

        out_ready = 1'b1;
        do_start(1'b0, 5'd0);
        drain(0, 0, 0, 0, 200);
        check_sweep(1, 1);
        chk("sweep_which_reg", 64'(which_reg), 64'd15);

        do_start(1'b0, 5'd0);
        drain(1, 0, 0, 0, 1000);
        check_sweep(1, 0);

        out_ready = 1'b1;
        do_start(1'b0, 5'd0);
        drain(0, 1, 10, 0, 200);
        check_sweep(1, 1);
        repeat (5) @(negedge clk);
        chk("ignored_no_valid", 64'(out_valid), 64'd0);
        chk("ignored_not_busy", 64'(busy), 64'd0);
        do_start(1'b0, 5'd9);
        drain(0, 0, 0, 0, 200);
        check_sweep(1, 1);

        regs[3] = 32'd5;
        do_start(1'b0, 5'd0);
        drain(0, 0, 0, 1, 200);
        check_sweep(0, 1);
        if (words.size() > 3) chk("live_old", 64'(words[3][31:0]), 64'd5);
        do_start(1'b0, 5'd0);
        drain(0, 0, 0, 0, 200);
        check_sweep(0, 1);
        if (words.size() > 3) chk("live_new", 64'(words[3][31:0]), 64'd9);

        regs[3] = 32'hA000_0003;
        out_ready = 1'b0;
        do_start(1'b1, 5'd12);
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_rst_which_reg", 64'(which_reg), 64'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_done", 64'(done), 64'd0);
        chk("async_which_reg", 64'(which_reg), 64'd0);
        chk("async_out_idx", 64'(out_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        do_start(1'b1, 5'd4);
        drain(0, 0, 0, 0, 50);
        chk("post_rst_count", 64'(words.size()), 64'd1);
        if (words.size() > 0) begin
            chk("post_rst_idx", 64'(words[0][36:32]), 64'd4);
            chk("post_rst_data", 64'(words[0][31:0]), 64'(32'hA000_0004));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
